iq_alu_queue: RTL and testbench

- 7-entry compacting issue queue for the ALU cluster. Sits directly upstream of the select stage.
- Accepts up to two renamed ALU ops per cycle from dispatch and holds them until both sources are ready. Snoops the ALU0/ALU1/MD/LS wakeup buses to set ready bits.
- Removes the entries that select grants via a 7-bit one-hot-per-slot enable.
- Slot 0 is always the oldest, so select's lowest-index priority is age order.

---
 rtl/iq_pkg.sv | 34 +++
 rtl/iq_wakeup_match.sv | 22 ++
 rtl/iq_alu_queue.sv | 161 ++++++++++++++++
 tb/tb_iq_alu_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - shared entry layout and sizing for the issue queues
package iq_pkg;

  localparam int IQ_DEPTH    = 7;
  localparam int TAG_W       = 5;
  localparam int IQ_ENTRY_W  = 21;
  localparam int IQ_NUM_BUS  = 4;

  // Entry field positions
  localparam int IQ_VALID    = 20;
  localparam int IQ_DST_MSB  = 19;
  localparam int IQ_DST_LSB  = 15;
  localparam int IQ_RDY1     = 14;
  localparam int IQ_SRC1_MSB = 13;
  localparam int IQ_SRC1_LSB = 9;
  localparam int IQ_DSTEN    = 8;
  localparam int IQ_RDY2     = 7;
  localparam int IQ_SRC2_MSB = 6;
  localparam int IQ_SRC2_LSB = 2;
  localparam int IQ_OP_MSB   = 1;
  localparam int IQ_OP_LSB   = 0;

  typedef logic [IQ_ENTRY_W-1:0] iq_entry_t;

  // Sets (never clears) the source ready bits on a wakeup hit
  function automatic iq_entry_t iq_set_rdy(iq_entry_t e, logic hit1, logic hit2);
    iq_entry_t r;
    r = e;
    r[IQ_RDY1] = e[IQ_RDY1] | hit1;
    r[IQ_RDY2] = e[IQ_RDY2] | hit2;
    return r;
  endfunction

endpackage

// File: rtl/iq_wakeup_match.sv
// rtl/iq_wakeup_match.sv - compares one source tag against all wakeup buses
module iq_wakeup_match #(
  parameter int TAG_W   = 5,
  parameter int NUM_BUS = 4
) (
  input  logic [TAG_W-1:0]         tag,
  input  logic [NUM_BUS*TAG_W-1:0] bus_tags,
  input  logic [NUM_BUS-1:0]       bus_en,
  output logic                     hit
);

  // Hit when any enabled bus broadcasts this tag
  always_comb begin
    hit = 1'b0;
    for (int b = 0; b < NUM_BUS; b++) begin
      if (bus_en[b] && (bus_tags[b*TAG_W +: TAG_W] == tag)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iq_alu_queue.sv
// rtl/iq_alu_queue.sv - 7-entry compacting ALU issue queue with wakeup snoop
module iq_alu_queue #(
  parameter int DEPTH   = iq_pkg::IQ_DEPTH,
  parameter int ENTRY_W = iq_pkg::IQ_ENTRY_W,
  parameter int TAG_W   = iq_pkg::TAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din0,
  input  logic [ENTRY_W-1:0] din1,
  input  logic               din0_en,
  input  logic               din1_en,
  output logic               iq_ready,
  output logic [2:0]         iq_count,
  output logic [ENTRY_W-1:0] dout0,
  output logic [ENTRY_W-1:0] dout1,
  output logic [ENTRY_W-1:0] dout2,
  output logic [ENTRY_W-1:0] dout3,
  output logic [ENTRY_W-1:0] dout4,
  output logic [ENTRY_W-1:0] dout5,
  output logic [ENTRY_W-1:0] dout6,
  input  logic [DEPTH-1:0]   select_en,
  input  logic [TAG_W-1:0]   wakeup_reg_ALU0,
  input  logic [TAG_W-1:0]   wakeup_reg_ALU1,
  input  logic [TAG_W-1:0]   wakeup_reg_MD,
  input  logic [TAG_W-1:0]   wakeup_reg_LS,
  input  logic               wakeup_ALU_en0,
  input  logic               wakeup_ALU_en1,
  input  logic               wakeup_MD_en,
  input  logic               wakeup_LS_en
);
  import iq_pkg::*;

  logic [ENTRY_W-1:0]          slot_q     [DEPTH];
  logic [ENTRY_W-1:0]          slot_d     [DEPTH];
  logic [ENTRY_W-1:0]          slot_woken [DEPTH];
  logic [ENTRY_W-1:0]          dout_vec   [DEPTH];
  logic [DEPTH-1:0]            valid_vec;
  logic [DEPTH-1:0]            surv_vec;
  logic [2:0]                  count;
  logic [2:0]                  wr_idx;
  logic                        acc0, acc1;
  logic [IQ_NUM_BUS*TAG_W-1:0] bus_tags;
  logic [IQ_NUM_BUS-1:0]       bus_en;
  logic                        d0_hit1, d0_hit2, d1_hit1, d1_hit2;
  logic [ENTRY_W-1:0]          din0_w, din1_w;

  assign bus_tags = {wakeup_reg_LS, wakeup_reg_MD, wakeup_reg_ALU1, wakeup_reg_ALU0};
  assign bus_en   = {wakeup_LS_en, wakeup_MD_en, wakeup_ALU_en1, wakeup_ALU_en0};

  // Per-slot wakeup: resident entries pick up ready bits from this cycle's buses
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic hit1, hit2;

    iq_wakeup_match #(.TAG_W(TAG_W), .NUM_BUS(IQ_NUM_BUS)) u_match1 (
      .tag      (slot_q[i][IQ_SRC1_MSB:IQ_SRC1_LSB]),
      .bus_tags (bus_tags),
      .bus_en   (bus_en),
      .hit      (hit1)
    );

    iq_wakeup_match #(.TAG_W(TAG_W), .NUM_BUS(IQ_NUM_BUS)) u_match2 (
      .tag      (slot_q[i][IQ_SRC2_MSB:IQ_SRC2_LSB]),
      .bus_tags (bus_tags),
      .bus_en   (bus_en),
      .hit      (hit2)
    );

    assign valid_vec[i]  = slot_q[i][IQ_VALID];
    assign surv_vec[i]   = slot_q[i][IQ_VALID] & ~select_en[i];
    assign slot_woken[i] = iq_set_rdy(slot_q[i], hit1, hit2);
    assign dout_vec[i]   = slot_q[i][IQ_VALID] ? slot_q[i] : '0;
  end

  // Dispatch-side wakeup gives the same-cycle bypass for incoming entries
  iq_wakeup_match #(.TAG_W(TAG_W), .NUM_BUS(IQ_NUM_BUS)) u_d0_match1 (
    .tag(din0[IQ_SRC1_MSB:IQ_SRC1_LSB]), .bus_tags(bus_tags), .bus_en(bus_en), .hit(d0_hit1)
  );
  iq_wakeup_match #(.TAG_W(TAG_W), .NUM_BUS(IQ_NUM_BUS)) u_d0_match2 (
    .tag(din0[IQ_SRC2_MSB:IQ_SRC2_LSB]), .bus_tags(bus_tags), .bus_en(bus_en), .hit(d0_hit2)
  );
  iq_wakeup_match #(.TAG_W(TAG_W), .NUM_BUS(IQ_NUM_BUS)) u_d1_match1 (
    .tag(din1[IQ_SRC1_MSB:IQ_SRC1_LSB]), .bus_tags(bus_tags), .bus_en(bus_en), .hit(d1_hit1)
  );
  iq_wakeup_match #(.TAG_W(TAG_W), .NUM_BUS(IQ_NUM_BUS)) u_d1_match2 (
    .tag(din1[IQ_SRC2_MSB:IQ_SRC2_LSB]), .bus_tags(bus_tags), .bus_en(bus_en), .hit(d1_hit2)
  );

  // Incoming entries are marked valid here so dispatch need not drive bit 20
  always_comb begin
    din0_w           = iq_set_rdy(din0, d0_hit1, d0_hit2);
    din1_w           = iq_set_rdy(din1, d1_hit1, d1_hit2);
    din0_w[IQ_VALID] = 1'b1;
    din1_w[IQ_VALID] = 1'b1;
  end

  // Occupancy from registered valid bits only; same-cycle grants are not credited
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + {2'b00, valid_vec[i]};
    end
  end

  assign iq_count = count;
  assign iq_ready = (count <= 3'(DEPTH - 2));
  assign acc0     = din0_en & iq_ready;
  assign acc1     = din1_en & iq_ready;

  // Compaction: each survivor lands at the running count of survivors below it,
  // then accepted dispatches append in din0, din1 order
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i] = '0;
    end
    wr_idx = '0;
    if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (surv_vec[i]) begin
          slot_d[wr_idx] = slot_woken[i];
          wr_idx         = wr_idx + 3'd1;
        end
      end
      // iq_ready caps survivors at DEPTH-2, so both appends stay in range
      if (acc0) begin
        slot_d[wr_idx] = din0_w;
        wr_idx         = wr_idx + 3'd1;
      end
      if (acc1) begin
        slot_d[wr_idx] = din1_w;
      end
    end
  end

  // Slot storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign dout0 = dout_vec[0];
  assign dout1 = dout_vec[1];
  assign dout2 = dout_vec[2];
  assign dout3 = dout_vec[3];
  assign dout4 = dout_vec[4];
  assign dout5 = dout_vec[5];
  assign dout6 = dout_vec[6];

  // Select must only grant occupied slots; such grants are otherwise ignored
  a_grant_valid: assert property (@(posedge clk) disable iff (!rst_n)
    ((select_en & ~valid_vec) == '0));

endmodule

// File: tb/tb_iq_alu_queue.sv
// tb/tb_iq_alu_queue.sv - table-driven scoreboard bench for iq_alu_queue
module tb_iq_alu_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [20:0] din0, din1;
  logic        din0_en, din1_en;
  logic        iq_ready;
  logic [2:0]  iq_count;
  logic [20:0] dout0, dout1, dout2, dout3, dout4, dout5, dout6;
  logic [6:0]  select_en;
  logic [4:0]  wakeup_reg_ALU0, wakeup_reg_ALU1, wakeup_reg_MD, wakeup_reg_LS;
  logic        wakeup_ALU_en0, wakeup_ALU_en1, wakeup_MD_en, wakeup_LS_en;

  always #5 clk = ~clk;

  iq_alu_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .din0(din0), .din1(din1), .din0_en(din0_en), .din1_en(din1_en),
    .iq_ready(iq_ready), .iq_count(iq_count),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .dout4(dout4), .dout5(dout5), .dout6(dout6),
    .select_en(select_en),
    .wakeup_reg_ALU0(wakeup_reg_ALU0), .wakeup_reg_ALU1(wakeup_reg_ALU1),
    .wakeup_reg_MD(wakeup_reg_MD), .wakeup_reg_LS(wakeup_reg_LS),
    .wakeup_ALU_en0(wakeup_ALU_en0), .wakeup_ALU_en1(wakeup_ALU_en1),
    .wakeup_MD_en(wakeup_MD_en), .wakeup_LS_en(wakeup_LS_en)
  );

  typedef struct {
    logic [20:0] d0, d1;
    logic        e0, e1;
    logic [6:0]  sel;
    logic        fl;
    logic [19:0] wtag;   // {LS, MD, ALU1, ALU0}
    logic [3:0]  wen;    // {LS, MD, ALU1, ALU0}
    int          exp_cnt;
    logic [20:0] exp_d0;
  } vec_t;

  typedef struct {
    logic [20:0] d [7];
    int          cnt;
    logic        rdy;
  } exp_t;

  vec_t        tbl [14];
  exp_t        exp_q [$];
  logic [20:0] mq [$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [20:0] mk(int dst, int r1, int s1, int de, int r2, int s2, int op);
    return {1'b0, 5'(dst), 1'(r1), 5'(s1), 1'(de), 1'(r2), 5'(s2), 2'(op)};
  endfunction

  function automatic logic [20:0] vld(logic [20:0] e);
    return e | 21'h100000;
  endfunction

  function automatic logic [19:0] wt(int alu0, int alu1, int md, int ls);
    return {5'(ls), 5'(md), 5'(alu1), 5'(alu0)};
  endfunction

  function automatic vec_t mkv(logic [20:0] d0, logic e0, logic [20:0] d1, logic e1,
                               logic [6:0] sel, logic fl, logic [19:0] wtag,
                               logic [3:0] wen, int cnt, logic [20:0] ed0);
    vec_t v;
    v.d0 = d0; v.e0 = e0; v.d1 = d1; v.e1 = e1; v.sel = sel; v.fl = fl;
    v.wtag = wtag; v.wen = wen; v.exp_cnt = cnt; v.exp_d0 = ed0;
    return v;
  endfunction

  function automatic logic [20:0] mwake(logic [20:0] e, logic [19:0] t, logic [3:0] en);
    logic [20:0] r;
    logic [4:0]  bt;
    r = e;
    for (int b = 0; b < 4; b++) begin
      bt = t[b*5 +: 5];
      if (en[b] && bt == e[13:9]) r[14] = 1'b1;
      if (en[b] && bt == e[6:2])  r[7]  = 1'b1;
    end
    return r;
  endfunction

  task automatic push_expect();
    exp_t e;
    for (int i = 0; i < 7; i++) e.d[i] = (i < mq.size()) ? mq[i] : 21'h0;
    e.cnt = mq.size();
    e.rdy = (mq.size() <= 5);
    exp_q.push_back(e);
  endtask

  task automatic model_step(vec_t v);
    bit rdy;
    if (v.fl) begin
      mq.delete();
    end else begin
      rdy = (mq.size() <= 5);
      for (int i = mq.size() - 1; i >= 0; i--) if (v.sel[i]) mq.delete(i);
      if (rdy && v.e0) mq.push_back(vld(v.d0));
      if (rdy && v.e1) mq.push_back(vld(v.d1));
      foreach (mq[i]) mq[i] = mwake(mq[i], v.wtag, v.wen);
    end
    push_expect();
  endtask

  task automatic check_outputs(string tag);
    exp_t        e;
    logic [20:0] act [7];
    int          bad;
    act = '{dout0, dout1, dout2, dout3, dout4, dout5, dout6};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: no expected entry queued", tag);
      return;
    end
    e = exp_q.pop_front();
    bad = -1;
    for (int i = 0; i < 7; i++) if (bad < 0 && act[i] !== e.d[i]) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s dout%0d: got %h expected %h", tag, bad, act[bad], e.d[bad]);
    end
    checks++;
    if (iq_count !== 3'(e.cnt)) begin
      errors++;
      $display("FAIL %s iq_count: got %0d expected %0d", tag, iq_count, e.cnt);
    end
    checks++;
    if (iq_ready !== e.rdy) begin
      errors++;
      $display("FAIL %s iq_ready: got %b expected %b", tag, iq_ready, e.rdy);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; din0 = '0; din1 = '0; din0_en = 1'b0; din1_en = 1'b0;
    select_en = '0;
    {wakeup_reg_LS, wakeup_reg_MD, wakeup_reg_ALU1, wakeup_reg_ALU0} = '0;
    {wakeup_LS_en, wakeup_MD_en, wakeup_ALU_en1, wakeup_ALU_en0} = '0;
  endtask

  task automatic apply_vec(vec_t v, int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    din0 = v.d0; din1 = v.d1; din0_en = v.e0; din1_en = v.e1;
    select_en = v.sel; flush = v.fl;
    {wakeup_reg_LS, wakeup_reg_MD, wakeup_reg_ALU1, wakeup_reg_ALU0} = v.wtag;
    {wakeup_LS_en, wakeup_MD_en, wakeup_ALU_en1, wakeup_ALU_en0} = v.wen;
    model_step(v);
    @(posedge clk);
    #1;
    idle_inputs();
    check_outputs(tag);
    checks++;
    if (iq_count !== 3'(v.exp_cnt)) begin
      errors++;
      $display("FAIL %s table count: got %0d expected %0d", tag, iq_count, v.exp_cnt);
    end
    checks++;
    if (dout0 !== v.exp_d0) begin
      errors++;
      $display("FAIL %s table dout0: got %h expected %h", tag, dout0, v.exp_d0);
    end
  endtask

  initial begin
    logic [20:0] e0, e1, x3, x4, x5, x6, h1, h2, y, fz;
    logic [20:0] a, b, c, d, e, f, g, hh;
    vec_t        idle;

    e0 = mk(1, 1, 3, 1, 1, 4, 0);   e1 = mk(2, 0, 9, 1, 0, 10, 1);
    x3 = mk(3, 1, 1, 1, 1, 2, 0);   x4 = mk(4, 0, 20, 1, 1, 6, 1);
    x5 = mk(5, 1, 7, 0, 1, 8, 2);   x6 = mk(6, 0, 21, 1, 0, 22, 3);
    h1 = mk(7, 0, 23, 1, 0, 24, 0); h2 = mk(8, 1, 0, 1, 1, 0, 1);
    y  = mk(12, 1, 0, 1, 1, 0, 0);  fz = mk(13, 0, 30, 1, 0, 31, 2);
    a  = mk(14, 1, 1, 1, 1, 1, 0);  b  = mk(15, 1, 5, 1, 0, 12, 2);
    c  = mk(16, 0, 17, 1, 1, 0, 1); d  = mk(17, 1, 2, 0, 1, 3, 0);
    e  = mk(18, 0, 19, 1, 0, 19, 3); f = mk(19, 1, 4, 1, 1, 4, 2);
    g  = mk(20, 0, 25, 1, 0, 26, 1); hh = mk(21, 1, 27, 0, 1, 28, 0);

    tbl[0]  = mkv(e0, 1, '0, 0, 7'b0, 0, '0, 4'b0, 1, vld(e0));
    tbl[1]  = mkv(e1, 1, '0, 0, 7'b0, 0, wt(0, 0, 9, 0), 4'b0100, 2, vld(e0));
    tbl[2]  = mkv(x3, 1, x4, 1, 7'b0, 0, '0, 4'b0, 4, vld(e0));
    tbl[3]  = mkv(x5, 1, x6, 1, 7'b0, 0, '0, 4'b0, 6, vld(e0));
    tbl[4]  = mkv(h1, 1, h2, 1, 7'b0, 0, '0, 4'b0, 6, vld(e0));
    tbl[5]  = mkv(h1, 1, h2, 1, 7'b0000011, 0, '0, 4'b0, 4, vld(x3));
    tbl[6]  = mkv('0, 0, y, 1, 7'b0, 0, '0, 4'b0, 5, vld(x3));
    tbl[7]  = mkv(fz, 1, '0, 0, 7'b0000001, 1, '0, 4'b0, 0, 21'h0);
    tbl[8]  = mkv(a, 1, b, 1, 7'b0, 0, '0, 4'b0, 2, vld(a));
    tbl[9]  = mkv(c, 1, d, 1, 7'b0, 0, '0, 4'b0, 4, vld(a));
    tbl[10] = mkv(e, 1, '0, 0, 7'b0, 0, '0, 4'b0, 5, vld(a));
    tbl[11] = mkv(f, 1, '0, 0, 7'b0000101, 0, '0, 4'b0, 4, vld(b));
    tbl[12] = mkv('0, 0, '0, 0, 7'b0, 0, wt(19, 0, 0, 12), 4'b1001, 4, vld(b) | 21'h80);
    tbl[13] = mkv(g, 1, hh, 1, 7'b0001111, 0, wt(0, 25, 0, 0), 4'b0010, 2, vld(g) | 21'h4000);

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_expect();
    check_outputs("reset");

    for (int i = 0; i < 14; i++) apply_vec(tbl[i], i);

    // Async reset between edges must clear outputs before the next clock
    idle = mkv(a, 1, b, 1, 7'b0, 0, '0, 4'b0, 4, vld(g) | 21'h4000);
    apply_vec(idle, 14);
    #3 rst_n = 1'b0;
    #1;
    mq.delete();
    push_expect();
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_expect();
    check_outputs("post_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
